// File: rtl/rv32m_muldiv_ctrl.sv
// RV32M multiply/divide sequencer: 2-cycle registered multiply, 32-step restoring divider, held result.
// Optional MULDIV_EARLY_OUT_EN: divide-by-zero / signed-overflow divides finish one cycle after accept.
module rv32m_muldiv_ctrl #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [XLEN-1:0]  in_a,
    input  logic [XLEN-1:0]  in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_MUL  = 3'd1;
    localparam logic [2:0] ST_DIV  = 3'd2;
    localparam logic [2:0] ST_FIX  = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

    logic [2:0]       state_reg, state_next;
    logic [2:0]       op_reg, op_next;
    logic [XLEN-1:0]  a_reg, a_next;
    logic [XLEN-1:0]  b_reg, b_next;
    logic [TAG_W-1:0] tag_reg, tag_next;
    logic [XLEN-1:0]  rem_reg, rem_next;
    logic [XLEN-1:0]  quo_reg, quo_next;
    logic [XLEN-1:0]  dvsr_reg, dvsr_next;
    logic [5:0]       cnt_reg, cnt_next;
    logic [XLEN-1:0]  res_reg, res_next;
    logic [TAG_W-1:0] otag_reg, otag_next;

    // ISA-defined results for x/0 and MIN/-1; identical whichever path produces them.
    function automatic logic [XLEN-1:0] special_val(input logic is_rem, input logic dz,
                                                    input logic [XLEN-1:0] a);
        if (dz)
            return is_rem ? a : '1;
        return is_rem ? '0 : a;
    endfunction

    // Operand magnitudes for the divider; bit 0 of funct3 clear means signed divide/remainder.
    logic [XLEN-1:0] in_a_abs, in_b_abs;
    assign in_a_abs = (!in_op[0] && in_a[XLEN-1]) ? -in_a : in_a;
    assign in_b_abs = (!in_op[0] && in_b[XLEN-1]) ? -in_b : in_b;

    logic            early_out;
    logic [XLEN-1:0] early_res;
`ifdef MULDIV_EARLY_OUT_EN
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
    logic in_dz, in_ovf;
    assign in_dz     = (in_b == '0);
    assign in_ovf    = !in_op[0] && (in_a == MIN_NEG) && (in_b == '1);
    assign early_out = in_dz || in_ovf;
    assign early_res = special_val(in_op[1], in_dz, in_a);
`else
    assign early_out = 1'b0;
    assign early_res = '0;
`endif

    // Multiply: sign-extend each operand to 2*XLEN so one product covers all four variants.
    logic            mul_a_sgn, mul_b_sgn;
    logic [2*XLEN-1:0] mul_a_ext, mul_b_ext, mul_prod;
    logic [XLEN-1:0] mul_res;
    assign mul_a_sgn = (op_reg[1:0] == 2'b01 || op_reg[1:0] == 2'b10) && a_reg[XLEN-1];
    assign mul_b_sgn = (op_reg[1:0] == 2'b01) && b_reg[XLEN-1];
    assign mul_a_ext = {{XLEN{mul_a_sgn}}, a_reg};
    assign mul_b_ext = {{XLEN{mul_b_sgn}}, b_reg};
    assign mul_prod  = mul_a_ext * mul_b_ext;
    assign mul_res   = (op_reg[1:0] == 2'b00) ? mul_prod[XLEN-1:0] : mul_prod[2*XLEN-1:XLEN];

    // One restoring step: shift in next dividend bit, subtract if it fits.
    logic [XLEN:0]   div_shift;
    logic            div_ge;
    logic [XLEN-1:0] div_diff;
    assign div_shift = {rem_reg, quo_reg[XLEN-1]};
    assign div_ge    = (div_shift >= {1'b0, dvsr_reg});
    assign div_diff  = div_shift[XLEN-1:0] - dvsr_reg;

    logic            fix_dz, fix_ovf;
    logic [XLEN-1:0] fix_quo, fix_rem, fix_res;
    assign fix_dz  = (b_reg == '0);
    assign fix_ovf = !op_reg[0] && (a_reg == {1'b1, {(XLEN-1){1'b0}}}) && (b_reg == '1);
    assign fix_quo = (!op_reg[0] && (a_reg[XLEN-1] ^ b_reg[XLEN-1])) ? -quo_reg : quo_reg;
    assign fix_rem = (!op_reg[0] && a_reg[XLEN-1]) ? -rem_reg : rem_reg;
    assign fix_res = (fix_dz || fix_ovf) ? special_val(op_reg[1], fix_dz, a_reg)
                                         : (op_reg[1] ? fix_rem : fix_quo);

    always_comb begin
        state_next = state_reg;
        op_next    = op_reg;
        a_next     = a_reg;
        b_next     = b_reg;
        tag_next   = tag_reg;
        rem_next   = rem_reg;
        quo_next   = quo_reg;
        dvsr_next  = dvsr_reg;
        cnt_next   = cnt_reg;
        res_next   = res_reg;
        otag_next  = otag_reg;
        if (flush) begin
            state_next = ST_IDLE;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (in_valid) begin
                        op_next   = in_op;
                        a_next    = in_a;
                        b_next    = in_b;
                        tag_next  = in_tag;
                        rem_next  = '0;
                        quo_next  = in_a_abs;
                        dvsr_next = in_b_abs;
                        if (!in_op[2]) begin
                            state_next = ST_MUL;
                        end else if (early_out) begin
                            state_next = ST_DONE;
                            res_next   = early_res;
                            otag_next  = in_tag;
                        end else begin
                            state_next = ST_DIV;
                            cnt_next   = 6'd32;
                        end
                    end
                end
                ST_MUL: begin
                    state_next = ST_DONE;
                    res_next   = mul_res;
                    otag_next  = tag_reg;
                end
                ST_DIV: begin
                    rem_next = div_ge ? div_diff : div_shift[XLEN-1:0];
                    quo_next = {quo_reg[XLEN-2:0], div_ge};
                    cnt_next = cnt_reg - 6'd1;
                    if (cnt_reg == 6'd1)
                        state_next = ST_FIX;
                end
                ST_FIX: begin
                    state_next = ST_DONE;
                    res_next   = fix_res;
                    otag_next  = tag_reg;
                end
                ST_DONE: begin
                    if (out_ready)
                        state_next = ST_IDLE;
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            op_reg    <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            tag_reg   <= '0;
            rem_reg   <= '0;
            quo_reg   <= '0;
            dvsr_reg  <= '0;
            cnt_reg   <= '0;
            res_reg   <= '0;
            otag_reg  <= '0;
        end else begin
            state_reg <= state_next;
            op_reg    <= op_next;
            a_reg     <= a_next;
            b_reg     <= b_next;
            tag_reg   <= tag_next;
            rem_reg   <= rem_next;
            quo_reg   <= quo_next;
            dvsr_reg  <= dvsr_next;
            cnt_reg   <= cnt_next;
            res_reg   <= res_next;
            otag_reg  <= otag_next;
        end
    end

    assign in_ready   = (state_reg == ST_IDLE) && !flush;
    assign out_valid  = (state_reg == ST_DONE);
    assign busy       = (state_reg != ST_IDLE);
    assign out_result = res_reg;
    assign out_tag    = otag_reg;
endmodule
